// File: rtl/sramlike_arbiter_pkg.sv
// Shared types and constants for the sram-like port arbiter.
// State encoding, owner codes and transfer size codes.
package sramlike_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sramlike_rr_picker.sv
// Two-way requester picker: fixed priority (data first)
// or round-robin (side not served last wins a tie).
module sramlike_rr_picker
    import sramlike_arbiter_pkg::*;
#(
    parameter int unsigned ARB_MODE = 0
) (
    input  logic [1:0] reqs_i,
    input  logic       last_served_i,
    output logic       winner_o
);

    // Pick an owner from the {data, inst} request pair
    always_comb begin
        winner_o = OWNER_INST;
        case (reqs_i)
            2'b01:   winner_o = OWNER_INST;
            2'b10:   winner_o = OWNER_DATA;
            2'b11:   winner_o = (ARB_MODE == 0) ? OWNER_DATA
                                                : ~last_served_i;
            default: winner_o = OWNER_INST;
        endcase
    end

endmodule

// File: rtl/sramlike_arbiter.sv
// Shares one sram-like memory port between the inst and data
// masters, one outstanding transaction at a time.
module sramlike_arbiter
    import sramlike_arbiter_pkg::*;
#(
    parameter int unsigned ARB_MODE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok
);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic       winner;
    logic       own_req;

    sramlike_rr_picker #(
        .ARB_MODE (ARB_MODE)
    ) u_picker (
        .reqs_i        ({data_req, inst_req}),
        .last_served_i (last_q),
        .winner_o      (winner)
    );

    assign own_req    = (owner_q == OWNER_DATA) ? data_req : inst_req;
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

    // State, owner and last-served registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWNER_INST;
            last_q  <= OWNER_INST;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // Next state, port mux and handshake routing to the owner
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_size     = 2'd0;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (inst_req || data_req) begin
                    owner_d = winner;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!own_req) begin
                    // requester withdrew before acceptance
                    state_d = IDLE;
                end else begin
                    mem_req = 1'b1;
                    if (owner_q == OWNER_DATA) begin
                        mem_wr    = data_wr;
                        mem_size  = data_size;
                        mem_addr  = data_addr;
                        mem_wdata = data_wdata;
                    end else begin
                        mem_wr    = inst_wr;
                        mem_size  = inst_size;
                        mem_addr  = inst_addr;
                        mem_wdata = inst_wdata;
                    end
                    if (mem_addr_ok) begin
                        data_addr_ok = (owner_q == OWNER_DATA);
                        inst_addr_ok = (owner_q == OWNER_INST);
                        last_d       = owner_q;
                        if (mem_data_ok) begin
                            data_data_ok = (owner_q == OWNER_DATA);
                            inst_data_ok = (owner_q == OWNER_INST);
                            state_d      = IDLE;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                data_data_ok = mem_data_ok && (owner_q == OWNER_DATA);
                inst_data_ok = mem_data_ok && (owner_q == OWNER_INST);
                if (mem_data_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sramlike_arbiter.sv
// Directed bench for sramlike_arbiter: one fixed-priority and
// one round-robin instance driven by the same stimulus.
module tb_sramlike_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [31:0] mem_rdata;
    logic        mem_addr_ok, mem_data_ok;

    logic [31:0] a_inst_rdata, a_data_rdata, a_mem_addr, a_mem_wdata;
    logic        a_inst_addr_ok, a_inst_data_ok;
    logic        a_data_addr_ok, a_data_data_ok, a_mem_req, a_mem_wr;
    logic [1:0]  a_mem_size;

    logic [31:0] b_inst_rdata, b_data_rdata, b_mem_addr, b_mem_wdata;
    logic        b_inst_addr_ok, b_inst_data_ok;
    logic        b_data_addr_ok, b_data_data_ok, b_mem_req, b_mem_wr;
    logic [1:0]  b_mem_size;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    sramlike_arbiter #(.ARB_MODE(0)) u0 (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_rdata(a_inst_rdata), .inst_addr_ok(a_inst_addr_ok),
        .inst_data_ok(a_inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(a_data_rdata), .data_addr_ok(a_data_addr_ok),
        .data_data_ok(a_data_data_ok),
        .mem_req(a_mem_req), .mem_wr(a_mem_wr), .mem_size(a_mem_size),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(mem_rdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok)
    );

    sramlike_arbiter #(.ARB_MODE(1)) u1 (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_rdata(b_inst_rdata), .inst_addr_ok(b_inst_addr_ok),
        .inst_data_ok(b_inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(b_data_rdata), .data_addr_ok(b_data_addr_ok),
        .data_data_ok(b_data_data_ok),
        .mem_req(b_mem_req), .mem_wr(b_mem_wr), .mem_size(b_mem_size),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(mem_rdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = 2'd2;
        inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2'd2;
        data_addr = 0; data_wdata = 0;
        mem_rdata = 0; mem_addr_ok = 0; mem_data_ok = 0;
        step; step;
        #1;
        chk("rst_mem_req", {31'd0, a_mem_req}, 0);
        chk("rst_inst_aok", {31'd0, a_inst_addr_ok}, 0);

        // 1: single inst read, addr_ok +1, data_ok +2
        rst = 0; inst_req = 1; inst_addr = 32'hBFC00000;
        #1;
        chk("t1_idle_req", {31'd0, a_mem_req}, 0);
        step;
        #1;
        chk("t1_req", {31'd0, a_mem_req}, 1);
        chk("t1_addr", a_mem_addr, 32'hBFC00000);
        step;
        mem_addr_ok = 1;
        #1;
        chk("t1_iaok", {31'd0, a_inst_addr_ok}, 1);
        chk("t1_daok", {31'd0, a_data_addr_ok}, 0);
        step;
        inst_req = 0; mem_addr_ok = 0;
        #1;
        chk("t1_wait_req", {31'd0, a_mem_req}, 0);
        chk("t1_wait_dok", {31'd0, a_inst_data_ok}, 0);
        step;
        step;
        mem_data_ok = 1; mem_rdata = 32'h3C1DBFC0;
        #1;
        chk("t1_idok", {31'd0, a_inst_data_ok}, 1);
        chk("t1_rdata", a_inst_rdata, 32'h3C1DBFC0);
        chk("t1_ddok", {31'd0, a_data_data_ok}, 0);
        step;
        mem_data_ok = 0;
        #1;
        chk("t1_idok_once", {31'd0, a_inst_data_ok}, 0);

        // 2a: tie with last_served = inst, both modes pick data
        inst_req = 1; data_req = 1;
        inst_addr = 32'h1000; data_addr = 32'h2000;
        #1;
        chk("t2_idle", {31'd0, a_mem_req}, 0);
        step;
        mem_addr_ok = 1;
        #1;
        chk("t2_fp_addr", a_mem_addr, 32'h2000);
        chk("t2_rr_addr", b_mem_addr, 32'h2000);
        chk("t2_daok", {31'd0, a_data_addr_ok}, 1);
        chk("t2_iaok", {31'd0, a_inst_addr_ok}, 0);
        step;
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        #1;
        chk("t2_ddok", {31'd0, a_data_data_ok}, 1);
        chk("t2_idok", {31'd0, a_inst_data_ok}, 0);
        step;
        mem_data_ok = 0;
        #1;
        chk("t2_turn_idle", {31'd0, a_mem_req}, 0);
        step;
        mem_addr_ok = 1; mem_data_ok = 1;
        #1;
        chk("t2_inst_addr", a_mem_addr, 32'h1000);
        chk("t2_inst_aok", {31'd0, a_inst_addr_ok}, 1);
        chk("t2_inst_dok", {31'd0, a_inst_data_ok}, 1);
        step;
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 0;

        // 2b: serve data alone, then tie: fixed -> data, rr -> inst
        data_req = 1;
        step;
        mem_addr_ok = 1; mem_data_ok = 1;
        step;
        inst_req = 1; mem_addr_ok = 0; mem_data_ok = 0;
        step;
        mem_addr_ok = 1; mem_data_ok = 1;
        #1;
        chk("t2b_fp_addr", a_mem_addr, 32'h2000);
        chk("t2b_rr_addr", b_mem_addr, 32'h1000);
        chk("t2b_rr_iaok", {31'd0, b_inst_addr_ok}, 1);
        chk("t2b_rr_daok", {31'd0, b_data_addr_ok}, 0);
        chk("t2b_fp_ddok", {31'd0, a_data_data_ok}, 1);
        step;
        inst_req = 0; data_req = 0;
        mem_addr_ok = 0; mem_data_ok = 0;

        // 3: zero-latency data store
        data_req = 1; data_wr = 1; data_size = 2'd2;
        data_addr = 32'h80001000; data_wdata = 32'h12345678;
        step;
        mem_addr_ok = 1; mem_data_ok = 1;
        #1;
        chk("t3_wr", {31'd0, a_mem_wr}, 1);
        chk("t3_size", {30'd0, a_mem_size}, 2);
        chk("t3_addr", a_mem_addr, 32'h80001000);
        chk("t3_wdata", a_mem_wdata, 32'h12345678);
        chk("t3_daok", {31'd0, a_data_addr_ok}, 1);
        chk("t3_ddok", {31'd0, a_data_data_ok}, 1);
        step;
        data_req = 0; data_wr = 0;
        mem_addr_ok = 0; mem_data_ok = 0;
        #1;
        chk("t3_idle", {31'd0, a_mem_req}, 0);
        chk("t3_ddok_low", {31'd0, a_data_data_ok}, 0);

        // 4: unsolicited data_ok in IDLE and in REQ
        mem_data_ok = 1;
        #1;
        chk("t4_idle_idok", {31'd0, a_inst_data_ok}, 0);
        chk("t4_idle_ddok", {31'd0, a_data_data_ok}, 0);
        step;
        inst_req = 1; inst_addr = 32'h6000;
        #1;
        chk("t4_idle2_idok", {31'd0, a_inst_data_ok}, 0);
        chk("t4_idle2_req", {31'd0, a_mem_req}, 0);
        step;
        #1;
        chk("t4_req", {31'd0, a_mem_req}, 1);
        chk("t4_req_idok", {31'd0, a_inst_data_ok}, 0);
        chk("t4_req_iaok", {31'd0, a_inst_addr_ok}, 0);
        step;
        #1;
        chk("t4_req_hold", {31'd0, a_mem_req}, 1);
        mem_data_ok = 0; mem_addr_ok = 1;
        step;
        inst_req = 0; mem_addr_ok = 0;
        #1;
        chk("t4_wait_req", {31'd0, a_mem_req}, 0);
        chk("t4_wait_addr", a_mem_addr, 0);

        // 5: reset while in WAIT, late data_ok dropped
        rst = 1;
        step;
        rst = 0; mem_data_ok = 1;
        #1;
        chk("t5_idok", {31'd0, a_inst_data_ok}, 0);
        chk("t5_req", {31'd0, a_mem_req}, 0);
        chk("t5_iaok", {31'd0, a_inst_addr_ok}, 0);
        step;
        mem_data_ok = 0; inst_req = 1; inst_addr = 32'h3000;
        #1;
        chk("t5_idle", {31'd0, a_mem_req}, 0);
        step;
        mem_addr_ok = 1; mem_data_ok = 1;
        #1;
        chk("t5_addr", a_mem_addr, 32'h3000);
        chk("t5_idok2", {31'd0, a_inst_data_ok}, 1);

        // 6: both held, rr alternates starting with data
        data_req = 1; inst_addr = 32'h4000; data_addr = 32'h5000;
        step;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("t6_idle", {31'd0, b_mem_req}, 0);
            step;
            #1;
            chk("t6_rr_addr", b_mem_addr,
                (i % 2 == 0) ? 32'h5000 : 32'h4000);
            chk("t6_fp_addr", a_mem_addr, 32'h5000);
            step;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
